// File: rtl/period_meter.sv
// period_meter
//
// Measures the rising-to-rising period and the rising-to-falling high time of
// a square wave that is asynchronous to CLK. Both are reported in CLK cycles.
// The block also flags when no rising edge arrives before the counter saturates
// (TIMEOUT). It reports LOCK once LOCK_CNT consecutive periods fall within
// EXP_PERIOD +/- TOL.
//
// Ports
//   CLK           in   1      sole clock, rising edge
//   RESET         in   1      synchronous, active-low
//   SIG_IN        in   1      measured square wave, asynchronous to CLK
//   PERIOD        out  WIDTH  last rising-to-rising period
//   HIGH_TIME     out  WIDTH  last rising-to-falling high time
//   PERIOD_VALID  out  1      one-cycle pulse when PERIOD is updated
//   TIMEOUT       out  1      sticky, counter saturated without a rising edge
//   LOCK          out  1      LOCK_CNT consecutive in-tolerance periods
//
// Timing: SIG_IN passes through two synchronizer flops and one edge-detect
// flop. The detected edge is then registered once more before it reaches the
// FSM. As a result, PERIOD_VALID rises 3 clock edges after the first edge that
// samples SIG_IN high.
//
// Limit: high or low phases shorter than 2 CLK cycles are not guaranteed to be
// seen, because the asynchronous input may or may not be captured. This is an
// inherent limit of sampling, not an error condition.

module period_meter #(
  parameter int WIDTH      = 20,
  parameter int EXP_PERIOD = 100000,
  parameter int TOL        = 8,
  parameter int LOCK_CNT   = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             SIG_IN,
  output logic [WIDTH-1:0] PERIOD,
  output logic [WIDTH-1:0] HIGH_TIME,
  output logic             PERIOD_VALID,
  output logic             TIMEOUT,
  output logic             LOCK
);

  localparam int MW     = $clog2(LOCK_CNT + 1);
  localparam int LO_INT = (EXP_PERIOD > TOL) ? (EXP_PERIOD - TOL) : 0;
  localparam int HI_INT = EXP_PERIOD + TOL;

  // Tolerance window, one bit wider than the counter so the bounds never wrap.
  localparam logic [WIDTH:0]   TOL_LO   = (WIDTH+1)'(LO_INT);
  localparam logic [WIDTH:0]   TOL_HI   = (WIDTH+1)'(HI_INT);
  localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [MW-1:0]    LOCK_TGT = MW'(LOCK_CNT);
  localparam logic [MW-1:0]    MATCH_ONE = MW'(1);

  typedef enum logic [0:0] {
    WAIT_EDGE = 1'b0,
    MEASURE   = 1'b1
  } state_t;

  state_t           state;
  logic             sync_p0;
  logic             sync_p1;
  logic             edge_p2;
  logic             rise_p3;
  logic             fall_p3;
  logic [WIDTH-1:0] counter;
  logic [MW-1:0]    match_cnt;

  function automatic logic in_tol(input logic [WIDTH-1:0] p);
    logic [WIDTH:0] p_ext;
    p_ext = {1'b0, p};
    return (p_ext >= TOL_LO) && (p_ext <= TOL_HI);
  endfunction

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state        <= WAIT_EDGE;
      sync_p0      <= 1'b0;
      sync_p1      <= 1'b0;
      edge_p2      <= 1'b0;
      rise_p3      <= 1'b0;
      fall_p3      <= 1'b0;
      counter      <= '0;
      match_cnt    <= '0;
      PERIOD       <= '0;
      HIGH_TIME    <= '0;
      PERIOD_VALID <= 1'b0;
      TIMEOUT      <= 1'b0;
      LOCK         <= 1'b0;
    end else begin
      // stage p0/p1: two-flop synchronizer
      sync_p0 <= SIG_IN;
      sync_p1 <= sync_p0;
      // stage p2: edge-detect history flop
      edge_p2 <= sync_p1;
      // stage p3: registered edge pulses feeding the FSM
      rise_p3 <= sync_p1 & ~edge_p2;
      fall_p3 <= ~sync_p1 & edge_p2;

      PERIOD_VALID <= 1'b0;

      case (state)
        WAIT_EDGE: begin
          // First rise only establishes the reference; no period yet.
          if (rise_p3) begin
            counter <= CNT_ONE;
            state   <= MEASURE;
          end
        end

        MEASURE: begin
          if (rise_p3) begin
            PERIOD       <= counter;
            PERIOD_VALID <= 1'b1;
            TIMEOUT      <= 1'b0;
            counter      <= CNT_ONE;
            if (in_tol(counter)) begin
              if (match_cnt != LOCK_TGT) begin
                match_cnt <= match_cnt + MATCH_ONE;
                if (match_cnt == LOCK_TGT - MATCH_ONE) begin
                  LOCK <= 1'b1;
                end
              end
            end else begin
              match_cnt <= '0;
              LOCK      <= 1'b0;
            end
          end else if (counter == CNT_MAX) begin
            // Saturated with no rise: PERIOD is held and the block re-arms.
            TIMEOUT   <= 1'b1;
            LOCK      <= 1'b0;
            match_cnt <= '0;
            counter   <= '0;
            state     <= WAIT_EDGE;
          end else begin
            counter <= counter + CNT_ONE;
            if (fall_p3) begin
              HIGH_TIME <= counter;
            end
          end
        end

        default: state <= WAIT_EDGE;
      endcase
    end
  end

endmodule

// File: tb/tb_period_meter.sv
module tb_period_meter;

  localparam int P_W    = 8;
  localparam int P_EXP  = 100;
  localparam int P_TOL  = 8;
  localparam int P_LOCK = 4;
  localparam int MAXC   = (1 << P_W) - 1;

  logic           clk;
  logic           reset;
  logic           sig_in;
  logic [P_W-1:0] period;
  logic [P_W-1:0] high_time;
  logic           period_valid;
  logic           timeout;
  logic           lock;

  int total = 0;
  int bad   = 0;

  period_meter #(
    .WIDTH     (P_W),
    .EXP_PERIOD(P_EXP),
    .TOL       (P_TOL),
    .LOCK_CNT  (P_LOCK)
  ) dut (
    .CLK         (clk),
    .RESET       (reset),
    .SIG_IN      (sig_in),
    .PERIOD      (period),
    .HIGH_TIME   (high_time),
    .PERIOD_VALID(period_valid),
    .TIMEOUT     (timeout),
    .LOCK        (lock)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  // x[k] is the value of SIG_IN sampled at edge k. The block acts at edge k on
  // an edge that appeared in the samples 3 edges earlier. Periods and high
  // times are differences of edge indices.
  bit model_ok = 0;
  int k = 0;
  bit h0, h1, h2, h3, h4;
  bit armed;
  int last;
  int m_per, m_high, streak;
  bit m_pv, m_to, m_lock;
  bit m_rise, m_fall;
  int dev;

  always @(posedge clk) begin
    if (reset === 1'b0) begin
      h0 = 0; h1 = 0; h2 = 0; h3 = 0; h4 = 0;
      armed = 0; last = 0;
      m_per = 0; m_high = 0; streak = 0;
      m_pv = 0; m_to = 0; m_lock = 0;
      model_ok = 1;
    end else begin
      h4 = h3; h3 = h2; h2 = h1; h1 = h0; h0 = sig_in;
      m_rise = h3 && !h4;
      m_fall = !h3 && h4;
      m_pv = 0;
      if (armed) begin
        if (m_rise) begin
          m_per = k - last;
          m_pv  = 1;
          m_to  = 0;
          last  = k;
          dev = m_per - P_EXP;
          if (dev < 0) dev = -dev;
          if (dev <= P_TOL) begin
            streak++;
            if (streak >= P_LOCK) m_lock = 1;
          end else begin
            streak = 0;
            m_lock = 0;
          end
        end else if (k - last == MAXC) begin
          m_to = 1; m_lock = 0; streak = 0; armed = 0;
        end else if (m_fall) begin
          m_high = k - last;
        end
      end else if (m_rise) begin
        armed = 1;
        last  = k;
      end
    end
    k++;
  end

  always @(negedge clk) begin
    if (model_ok) begin
      chk("model period_valid", period_valid, m_pv);
      chk("model period", period, m_per);
      chk("model high_time", high_time, m_high);
      chk("model timeout", timeout, m_to);
      chk("model lock", lock, m_lock);
    end
  end

  // Capture of the most recent PERIOD_VALID for the directed checks.
  int pv_cnt = 0;
  int cap_per, cap_high;
  bit cap_lock, cap_to;

  always @(negedge clk) begin
    if (period_valid === 1'b1) begin
      pv_cnt++;
      cap_per  = period;
      cap_high = high_time;
      cap_lock = lock;
      cap_to   = timeout;
    end
  end

  // Called at posedge+1; SIG_IN is sampled high on hi edges then low on lo.
  task automatic drive(input int hi, input int lo);
    sig_in = 1'b1;
    repeat (hi) @(posedge clk);
    #1;
    sig_in = 1'b0;
    repeat (lo) @(posedge clk);
    #1;
  endtask

  // Rise, 3 high samples, then low; checks the pulse lands exactly 3 edges on.
  task automatic lat_seq(input int exp_per, input int exp_high);
    sig_in = 1'b1;
    for (int j = 0; j < 6; j++) begin
      @(posedge clk);
      #1;
      if (j == 2) sig_in = 1'b0;
      chk($sformatf("latency pv edge%0d", j), period_valid, (j == 3) ? 1 : 0);
      if (j == 3) begin
        chk("latency period", period, exp_per);
        chk("latency high_time", high_time, exp_high);
      end
    end
  endtask

  typedef struct {
    int hi;
    int lo;
    bit pv;
    int per;
    int high;
    bit lck;
  } vec_t;

  vec_t tbl[19];
  int n0;
  int cnt;
  int tot;
  int hi;

  initial begin
    // Each record gives the expected result of the PERIOD_VALID caused by its
    // own rise, which closes the previous record's period.
    tbl[0]  = '{50, 50, 0,   0,  0, 0};
    tbl[1]  = '{50, 55, 1, 100, 50, 0};
    tbl[2]  = '{50, 55, 1, 105, 50, 0};
    tbl[3]  = '{40, 65, 1, 105, 50, 0};
    tbl[4]  = '{30, 79, 1, 105, 40, 1};
    tbl[5]  = '{ 3,  7, 1, 109, 30, 0};
    tbl[6]  = '{60, 32, 1,  10,  3, 0};
    tbl[7]  = '{50, 50, 1,  92, 60, 0};
    tbl[8]  = '{ 2, 10, 1, 100, 50, 0};
    tbl[9]  = '{50, 58, 1,  12,  2, 0};
    tbl[10] = '{50, 58, 1, 108, 50, 0};
    tbl[11] = '{50, 50, 1, 108, 50, 0};
    tbl[12] = '{50, 50, 1, 100, 50, 0};
    tbl[13] = '{50, 50, 1, 100, 50, 1};
    tbl[14] = '{10, 10, 1, 100, 50, 1};
    tbl[15] = '{ 5,  5, 1,  20, 10, 0};
    tbl[16] = '{45, 46, 1,  10,  5, 0};
    tbl[17] = '{46, 46, 1,  91, 45, 0};
    tbl[18] = '{10, 10, 1,  92, 46, 0};

    reset  = 1'b0;
    sig_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    chk("reset period", period, 0);
    chk("reset high_time", high_time, 0);
    chk("reset period_valid", period_valid, 0);
    chk("reset timeout", timeout, 0);
    chk("reset lock", lock, 0);

    for (int i = 0; i < 19; i++) begin
      n0 = pv_cnt;
      drive(tbl[i].hi, tbl[i].lo);
      chk($sformatf("tbl%0d pv count", i), pv_cnt - n0, tbl[i].pv);
      if (tbl[i].pv) begin
        chk($sformatf("tbl%0d period", i), cap_per, tbl[i].per);
        chk($sformatf("tbl%0d high_time", i), cap_high, tbl[i].high);
        chk($sformatf("tbl%0d lock", i), cap_lock, tbl[i].lck);
        chk($sformatf("tbl%0d timeout", i), cap_to, 0);
      end
    end

    // Latency, then a period of 10 with a 3-cycle high time.
    lat_seq(20, 10);
    repeat (4) @(posedge clk);
    #1;
    lat_seq(10, 3);

    // Held low after that rise: saturation at 255 counts.
    cnt = 0;
    while (timeout !== 1'b1 && cnt < 400) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    chk("timeout latency", cnt, 253);
    chk("timeout lock", lock, 0);
    chk("timeout period held", period, 10);
    n0 = pv_cnt;
    drive(10, 10);
    chk("rearm pv count", pv_cnt - n0, 0);
    chk("rearm timeout sticky", timeout, 1);
    drive(10, 10);
    chk("after rearm pv count", pv_cnt - n0, 1);
    chk("after rearm period", cap_per, 20);
    chk("after rearm timeout", cap_to, 0);

    // Reach lock, then reset in the low phase of a period.
    for (int i = 0; i < 5; i++) drive(50, 50);
    chk("pre-reset lock", lock, 1);
    drive(50, 25);
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    chk("midreset period", period, 0);
    chk("midreset high_time", high_time, 0);
    chk("midreset period_valid", period_valid, 0);
    chk("midreset timeout", timeout, 0);
    chk("midreset lock", lock, 0);
    repeat (24) @(posedge clk);
    #1;
    n0 = pv_cnt;
    drive(50, 50);
    chk("post-reset first rise pv", pv_cnt - n0, 0);
    drive(50, 50);
    chk("post-reset second rise pv", pv_cnt - n0, 1);
    chk("post-reset period", cap_per, 100);

    // Random periods, some near nominal, a few long enough to time out.
    for (int i = 0; i < 40; i++) begin
      cnt = $urandom_range(0, 19);
      if (cnt < 8)       tot = P_EXP - 12 + $urandom_range(0, 24);
      else if (cnt == 19) tot = 300;
      else               tot = $urandom_range(6, 140);
      hi = $urandom_range(2, tot - 2);
      drive(hi, tot - hi);
    end
    repeat (5) @(posedge clk);
    #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/period_meter.md
PERIOD_METER -- requirements
Module: period_meter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 20, giving the period counter width in bits.
REQ-002 The block SHALL have parameter EXP_PERIOD, default 100000, giving the expected period in CLK cycles.
REQ-003 The block SHALL have parameter TOL, default 8, giving the allowed absolute deviation in CLK cycles.
REQ-004 The block SHALL have parameter LOCK_CNT, default 4, giving the number of consecutive in-tolerance periods needed to assert LOCK.
REQ-005 CLK  input  1  sole clock; all state changes on rising edge.
REQ-006 RESET  input  1  synchronous, active-low reset.
REQ-007 SIG_IN  input  1  measured square wave, asynchronous to CLK (e.g. a divider output such as CLK_U/CLK_D).
REQ-008 PERIOD  output  WIDTH  last measured rising-to-rising period in CLK cycles.
REQ-009 HIGH_TIME  output  WIDTH  last measured rising-to-falling high time in CLK cycles.
REQ-010 PERIOD_VALID  output  1  one-cycle pulse when PERIOD is updated.
REQ-011 TIMEOUT  output  1  sticky flag, counter saturated without a rising edge.
REQ-012 LOCK  output  1  period within EXP_PERIOD+/-TOL for LOCK_CNT consecutive measurements.

Function
REQ-013 SIG_IN SHALL pass through a 2-flop synchronizer followed by a third flop for edge detection; rise = s2 & ~s3, fall = ~s2 & s3.
REQ-014 The FSM SHALL have states WAIT_EDGE (no reference edge yet) and MEASURE (counting since last rising edge).
REQ-015 In WAIT_EDGE, a detected rise SHALL load the counter with 1 and move to MEASURE; no PERIOD update occurs.
REQ-016 In MEASURE, the counter SHALL increment by 1 each cycle with no detected rise, so a signal with rising edges N cycles apart yields count N at the second rise.
REQ-017 In MEASURE, a detected rise SHALL register PERIOD <= counter, pulse PERIOD_VALID for exactly one cycle, reload counter with 1, and remain in MEASURE.
REQ-018 In MEASURE, a detected fall SHALL register HIGH_TIME <= counter; a fall in WAIT_EDGE SHALL be ignored.
REQ-019 PERIOD_VALID SHALL go high exactly 3 CLK cycles after the first CLK edge that samples SIG_IN high.
REQ-020 If the counter reaches 2^WIDTH-1 in MEASURE without a rise, the block SHALL set TIMEOUT, clear LOCK and the consecutive-match count, hold PERIOD, and return to WAIT_EDGE.
REQ-021 TIMEOUT SHALL stay set until the next PERIOD_VALID pulse or reset, whichever comes first.
REQ-022 On each PERIOD_VALID, a period with |PERIOD - EXP_PERIOD| <= TOL SHALL increment a saturating match count (saturating at LOCK_CNT); otherwise the count SHALL clear to 0 and LOCK SHALL deassert in the same cycle as PERIOD_VALID.
REQ-023 LOCK SHALL assert in the same cycle as the PERIOD_VALID that brings the match count to LOCK_CNT.
REQ-024 The tolerance comparison SHALL use WIDTH+1-bit arithmetic with no wrap-around; EXP_PERIOD - TOL SHALL be clamped at 0.
REQ-025 Pulses shorter than 2 CLK cycles are not guaranteed to be detected; this SHALL be documented as a limit, not an error.

Reset
REQ-026 While RESET=0 at a CLK edge, the block SHALL clear all synchronizer flops, counter, PERIOD, HIGH_TIME, PERIOD_VALID, TIMEOUT, LOCK and match count to 0, and enter WAIT_EDGE.
REQ-027 Reset asserted mid-measurement SHALL discard the partial count; the first rise after release SHALL only re-arm the block (no PERIOD_VALID).

Verification
REQ-028 Square wave, period 100000, 50% duty -> first PERIOD_VALID on the 2nd rise, PERIOD=100000, HIGH_TIME=50000.
REQ-029 Four consecutive periods of 100005 -> LOCK=1 with the 4th PERIOD_VALID; one period of 100009 -> LOCK=0 in the same cycle as that PERIOD_VALID.
REQ-030 SIG_IN held low after one rise, WIDTH=8 -> TIMEOUT=1 after 255 counts, state WAIT_EDGE; the next two rises -> PERIOD_VALID only on the second rise, TIMEOUT cleared then.
REQ-031 Period 10 with 3-cycle high time -> PERIOD=10, HIGH_TIME=3, PERIOD_VALID latency exactly 3 cycles from sampling.
REQ-032 RESET=0 for 1 cycle at mid-period after LOCK=1 -> all outputs 0 the next cycle, no PERIOD_VALID on the next rise, PERIOD_VALID with the correct period on the rise after that.
